boot_loader: RTL and testbench

Serial program loader that sits in front of the single-cycle core's instruction memory and its `INT`/`entryPoint` start inputs. It accepts a byte stream over a valid/ready handshake and assembles it into a word count header followed by that many 32-bit instruction words. It writes each word into instruction memory at consecutive word addresses. It then issues a one-cycle `INT` pulse with `entryPoint`, which starts the core at the loaded image.

---
 rtl/boot_loader_if.sv | 22 ++
 rtl/boot_loader.sv | 87 ++++++++
 tb/tb_boot_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream, instruction-memory write port and core start/status signals of the boot loader
interface boot_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        INT;
   logic [31:0] entryPoint;
   logic        busy;
   logic        done;
   logic        err;
   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, INT, entryPoint, busy, done, err
   );
   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, INT, entryPoint, busy, done, err
   );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: loads a counted little-endian word image into instruction memory, then pulses INT at entryPoint.
// Optional trailing XOR checksum byte when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_loader #(
   parameter logic [31:0] ENTRY     = 32'h28,
   parameter int          MAX_WORDS = 64
) (
   input  logic        clk,
   input  logic        resetn,
   boot_loader_if.slave bus
);
   localparam int WW = $clog2(MAX_WORDS + 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {HDR, LOAD, CHK, START, RUN, ERR} state_t;
   localparam state_t PAY_END = CHK;
   logic [7:0] csum;
`else
   typedef enum logic [2:0] {HDR, LOAD, START, RUN, ERR} state_t;
   localparam state_t PAY_END = START;
`endif
   state_t      state, nextState;
   logic [1:0]  byteIdx;
   logic [WW-1:0] wordIdx, cnt;
   logic [23:0] partial;
   logic [31:0] nextWord;
   logic        fire, lastByte;
   assign fire       = bus.in_valid && bus.in_ready;
   assign lastByte   = fire && byteIdx == 2'd3;
   assign nextWord   = {bus.in_data, partial};
`ifdef BOOT_LOADER_CHECKSUM_EN
   assign bus.in_ready = state == HDR || state == LOAD || state == CHK;
`else
   assign bus.in_ready = state == HDR || state == LOAD;
`endif
   assign bus.busy       = bus.in_ready;
   assign bus.entryPoint = ENTRY;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= HDR;
      else         state <= nextState;
   always_comb begin
      nextState = state;
      case (state)
         HDR:   if (lastByte) nextState = nextWord == '0 ? PAY_END : nextWord > 32'(MAX_WORDS) ? ERR : LOAD;
         LOAD:  if (lastByte && wordIdx + WW'(1) == cnt) nextState = PAY_END;
`ifdef BOOT_LOADER_CHECKSUM_EN
         CHK:   if (fire) nextState = bus.in_data == csum ? START : ERR;
`endif
         START: nextState = RUN;
         default: nextState = state;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= ENTRY;
         bus.mem_wdata <= '0;
         bus.INT       <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         byteIdx       <= '0;
         wordIdx       <= '0;
         cnt           <= '0;
         partial       <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum          <= '0;
`endif
      end else begin
         bus.mem_we <= state == LOAD && lastByte;
         bus.INT    <= state == START;
         bus.done   <= state == RUN;
         bus.err    <= state == ERR;
         if (fire && (state == HDR || state == LOAD)) begin
            partial <= nextWord[31:8];
            byteIdx <= byteIdx + 2'd1;
         end
         if (state == HDR && lastByte) cnt <= nextWord[WW-1:0];
         // write address is taken from the index of the word just completed
         if (state == LOAD && lastByte) begin
            bus.mem_addr  <= ENTRY + 32'({wordIdx, 2'b00});
            bus.mem_wdata <= nextWord;
            wordIdx       <= wordIdx + WW'(1);
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         if (state == LOAD && fire) csum <= csum ^ bus.in_data;
`endif
      end
   end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed streams against boot_loader with a write/INT monitor; honours BOOT_LOADER_CHECKSUM_EN.
module tb_boot_loader;
`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   logic clk = 1'b0;
   logic resetn = 1'b0;
   boot_loader_if bus();
   boot_loader dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   int nVec = 0, nBad = 0;
   int cyc = 0, nW = 0, nInt = 0, lastWeCyc = 0, intCyc = 0;
   logic [31:0] wAddr [0:7];
   logic [31:0] wData [0:7];
   logic [31:0] img [0:1] = '{32'h00100513, 32'h00B50633};
   logic [7:0]  ck;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (bus.mem_we) begin
         if (nW < 8) begin
            wAddr[nW] = bus.mem_addr;
            wData[nW] = bus.mem_wdata;
         end
         nW++;
         lastWeCyc = cyc;
      end
      if (bus.INT) begin
         nInt++;
         intCyc = cyc;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic clearMon();
      nW = 0; nInt = 0; lastWeCyc = 0; intCyc = 0;
   endtask
   task automatic doReset();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      clearMon();
   endtask
   task automatic sendByte(input logic [7:0] b, input int gap);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clk);
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask
   task automatic sendWord(input logic [31:0] w, input int gap, input logic acc);
      for (int k = 0; k < 4; k++) begin
         if (acc) ck ^= w[8*k +: 8];
         sendByte(w[8*k +: 8], gap);
      end
   endtask
   task automatic sendImage(input int n, input int gap, input logic bad);
      ck = '0;
      sendWord(32'(n), gap, 1'b0);
      for (int i = 0; i < n; i++) sendWord(img[i], gap, 1'b1);
      if (CK == 1) sendByte(bad ? 8'h00 : ck, gap);
      bus.in_valid = 1'b0;
   endtask
   task automatic waitEnd();
      for (int i = 0; i < 60 && !(bus.done || bus.err); i++) @(negedge clk);
      check("finish_timeout", 32'(bus.done || bus.err), 32'd1);
      repeat (3) @(negedge clk);
   endtask
   task automatic checkTwoWords(input string tag);
      check({tag, "_nw"}, nW, 2);
      check({tag, "_a0"}, wAddr[0], 32'h28);
      check({tag, "_d0"}, wData[0], 32'h00100513);
      check({tag, "_a1"}, wAddr[1], 32'h2C);
      check({tag, "_d1"}, wData[1], 32'h00B50633);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      doReset();
      check("rst_ready", bus.in_ready, 1);
      check("rst_busy", bus.busy, 1);
      check("rst_we", bus.mem_we, 0);
      check("rst_int", bus.INT, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_entry", bus.entryPoint, 32'h28);
      sendImage(2, 0, 1'b0);
      waitEnd();
      checkTwoWords("b2b");
      check("b2b_nint", nInt, 1);
      check("b2b_int_gap", intCyc - lastWeCyc, 1 + CK);
      check("b2b_done", bus.done, 1);
      check("b2b_err", bus.err, 0);
      check("b2b_ready", bus.in_ready, 0);
      check("b2b_busy", bus.busy, 0);
      sendByte(8'hAA, 0);
      sendByte(8'hBB, 0);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("run_ignore_nw", nW, 2);
      check("run_ignore_int", nInt, 1);
      doReset();
      sendWord(32'h41, 0, 1'b0);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("ovr_err", bus.err, 1);
      check("ovr_ready", bus.in_ready, 0);
      check("ovr_busy", bus.busy, 0);
      for (int i = 0; i < 8; i++) sendByte(8'h13, 0);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("ovr_nw", nW, 0);
      check("ovr_nint", nInt, 0);
      check("ovr_done", bus.done, 0);
      check("ovr_err_hold", bus.err, 1);
      doReset();
      sendImage(2, 3, 1'b0);
      waitEnd();
      checkTwoWords("stall");
      check("stall_nint", nInt, 1);
      check("stall_done", bus.done, 1);
      doReset();
      ck = '0;
      sendWord(32'h2, 0, 1'b0);
      sendWord(img[0], 0, 1'b1);
      sendByte(8'h33, 0);
      sendByte(8'h06, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_nw", nW, 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_ready", bus.in_ready, 1);
      check("mid_rst_we", bus.mem_we, 0);
      @(negedge clk);
      resetn = 1'b1;
      clearMon();
      img[0] = 32'h0000006F;
      sendImage(1, 0, 1'b0);
      waitEnd();
      check("mid_nw2", nW, 1);
      check("mid_a0", wAddr[0], 32'h28);
      check("mid_d0", wData[0], 32'h0000006F);
      check("mid_nint", nInt, 1);
      check("mid_done", bus.done, 1);
      img[0] = 32'h00100513;
      doReset();
      sendImage(0, 0, 1'b0);
      waitEnd();
      check("zero_nw", nW, 0);
      check("zero_nint", nInt, 1);
      check("zero_done", bus.done, 1);
      if (CK == 1) begin
         doReset();
         sendImage(2, 0, 1'b1);
         waitEnd();
         checkTwoWords("ckbad");
         check("ckbad_err", bus.err, 1);
         check("ckbad_nint", nInt, 0);
         check("ckbad_done", bus.done, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
